// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//    Shares the single-port data SRAM between the CPU MEM stage and the
//    external debug/loader port. One access per cycle: the CPU wins by
//    default and the loser is held off (cpu_stall / ext_gnt low). Read data
//    comes back from the SRAM one cycle after the grant and is steered to
//    whichever side issued that read.
//
// Ports
//    clk, rst                         clock and synchronous active-high reset
//    cpu_req/wen/addr/wdata           CPU request (held while cpu_stall=1)
//    cpu_stall                        CPU request not granted this cycle
//    cpu_rvalid/rdata                 CPU read return, one cycle after grant
//    ext_req/wen/addr/wdata           external request (held until ext_gnt)
//    ext_gnt                          external request accepted this cycle
//    ext_rvalid/rdata                 external read return
//    mem_en/wen/addr/wdata            SRAM command for the granted side
//    mem_rdata                        SRAM read data, valid cycle after a read
//
// Configuration
//    DMEM_ARB_STARVE_GUARD_EN  when defined, a 4-bit starvation counter forces
//                              one external grant after STARVE_LIMIT
//                              consecutive denied cycles. When undefined the
//                              CPU has strict priority and no counter exists.

module dmem_port_arbiter #(
   parameter int ADDR_W       = 10,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_wen,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ext_req,
   input  logic              ext_wen,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic              ext_gnt,
   output logic              ext_rvalid,
   output logic [DATA_W-1:0] ext_rdata,
   output logic              mem_en,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
      $error("dmem_port_arbiter: STARVE_LIMIT must be in 1..15");
   end

   typedef enum logic [1:0] {
      OWNER_NONE = 2'd0,
      OWNER_CPU  = 2'd1,
      OWNER_EXT  = 2'd2
   } owner_t;

   owner_t rd_owner;
   owner_t rd_owner_next;
   logic   force_ext;
   logic   cpu_gnt;

`ifdef DMEM_ARB_STARVE_GUARD_EN
   localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

   logic [3:0] starve_cnt;

   // Counts consecutive cycles the external side asked and was refused.
   // Any grant or a dropped request restarts the count; it parks at LIMIT
   // so the forced grant fires exactly once.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= 4'd0;
      end else if (!ext_req || ext_gnt) begin
         starve_cnt <= 4'd0;
      end else if (starve_cnt != LIMIT) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   assign force_ext = (starve_cnt == LIMIT);
`else
   assign force_ext = 1'b0;
`endif

   // Requests are ignored entirely while reset is held.
   assign cpu_gnt   = !rst && cpu_req && !force_ext;
   assign ext_gnt   = !rst && ext_req && (!cpu_req || force_ext);
   assign cpu_stall = cpu_req && !cpu_gnt;

   // SRAM command mux; address/data default to the CPU side since they are
   // don't-care whenever mem_en is low. Also decides who owns next cycle's
   // read return.
   always_comb begin
      mem_en        = 1'b0;
      mem_wen       = 1'b0;
      mem_addr      = cpu_addr;
      mem_wdata     = cpu_wdata;
      rd_owner_next = OWNER_NONE;
      if (cpu_gnt) begin
         mem_en  = 1'b1;
         mem_wen = cpu_wen;
         if (!cpu_wen) begin
            rd_owner_next = OWNER_CPU;
         end
      end else if (ext_gnt) begin
         mem_en    = 1'b1;
         mem_wen   = ext_wen;
         mem_addr  = ext_addr;
         mem_wdata = ext_wdata;
         if (!ext_wen) begin
            rd_owner_next = OWNER_EXT;
         end
      end
   end

   // Remembers which requester issued the read now in flight in the SRAM.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_owner <= OWNER_NONE;
      end else begin
         rd_owner <= rd_owner_next;
      end
   end

   // A read in flight when reset arrives is dropped, including during the
   // reset cycle itself.
   assign cpu_rvalid = !rst && (rd_owner == OWNER_CPU);
   assign ext_rvalid = !rst && (rd_owner == OWNER_EXT);
   assign cpu_rdata  = mem_rdata;
   assign ext_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
//    Directed and randomized bench for dmem_port_arbiter with a behavioural
//    SRAM and a reference model of the arbitration rules kept as integers.

module tb_dmem_port_arbiter;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;
   localparam int LIMIT  = 4;
`ifdef DMEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              cpu_req, cpu_wen;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_stall, cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;
   logic              ext_req, ext_wen;
   logic [ADDR_W-1:0] ext_addr;
   logic [DATA_W-1:0] ext_wdata;
   logic              ext_gnt, ext_rvalid;
   logic [DATA_W-1:0] ext_rdata;
   logic              mem_en, mem_wen;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              preload;
   logic [DATA_W-1:0] sram [0:(1<<ADDR_W)-1];

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];
   int                m_owner;
   logic [DATA_W-1:0] m_data;
   int                m_starve;
   bit                e_cgnt, e_egnt;
   bit                cpu_hold, ext_hold;
   int                ext_gnt_seen;

   dmem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
      .cpu_rdata(cpu_rdata),
      .ext_req(ext_req), .ext_wen(ext_wen), .ext_addr(ext_addr),
      .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
      .ext_rdata(ext_rdata),
      .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] initWord(input int i);
      if (i == 16) return 32'hDEADBEEF;
      return (i * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   // Behavioural single-port SRAM with one-cycle read latency.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < (1<<ADDR_W); i++) sram[i] <= initWord(i);
      end else if (mem_en) begin
         if (mem_wen) sram[mem_addr] <= mem_wdata;
         else         mem_rdata      <= sram[mem_addr];
      end
   end

   task automatic expectVal(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compares the DUT's combinational view of this cycle with the model.
   task automatic checkOutput();
      bit force_e;
      bit exp_en, exp_wen;
      force_e = GUARD && (m_starve == LIMIT);
      e_cgnt  = !rst && cpu_req && !force_e;
      e_egnt  = !rst && ext_req && (!cpu_req || force_e);
      exp_en  = e_cgnt || e_egnt;
      exp_wen = e_cgnt ? cpu_wen : (e_egnt ? ext_wen : 1'b0);
      expectVal("cpu_stall", cpu_stall, cpu_req && !e_cgnt);
      expectVal("ext_gnt", ext_gnt, e_egnt);
      expectVal("mem_en", mem_en, exp_en);
      expectVal("mem_wen", mem_wen, exp_wen);
      if (exp_en) begin
         expectVal("mem_addr", mem_addr, e_cgnt ? cpu_addr : ext_addr);
         if (exp_wen) expectVal("mem_wdata", mem_wdata, e_cgnt ? cpu_wdata : ext_wdata);
      end
      expectVal("cpu_rvalid", cpu_rvalid, !rst && m_owner == 1);
      expectVal("ext_rvalid", ext_rvalid, !rst && m_owner == 2);
      if (!rst && m_owner == 1) expectVal("cpu_rdata", cpu_rdata, m_data);
      if (!rst && m_owner == 2) expectVal("ext_rdata", ext_rdata, m_data);
   endtask

   // Drives one cycle of inputs, checks, advances the model and the clock.
   task automatic applyStimulus(input bit r, input bit cr, input bit cw,
                                input int ca, input logic [31:0] cd,
                                input bit er, input bit ew,
                                input int ea, input logic [31:0] ed);
      rst = r;
      cpu_req = cr; cpu_wen = cw; cpu_addr = ca[ADDR_W-1:0]; cpu_wdata = cd;
      ext_req = er; ext_wen = ew; ext_addr = ea[ADDR_W-1:0]; ext_wdata = ed;
      #1;
      checkOutput();
      if (ext_gnt) ext_gnt_seen++;
      if (r) begin
         m_owner  = 0;
         m_starve = 0;
      end else begin
         m_owner = 0;
         if (e_cgnt && !cw) begin
            m_owner = 1; m_data = shadow[ca];
         end else if (e_egnt && !ew) begin
            m_owner = 2; m_data = shadow[ea];
         end
         if (e_cgnt && cw) shadow[ca] = cd;
         if (e_egnt && ew) shadow[ea] = ed;
         if (!er || e_egnt) m_starve = 0;
         else if (m_starve < LIMIT) m_starve++;
      end
      cpu_hold = cr && !e_cgnt;
      ext_hold = er && !e_egnt;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit cr, cw, er, ew, r;
      int ca, ea;
      logic [31:0] cd, ed;

      rst = 1'b1; preload = 1'b1;
      cpu_req = 0; cpu_wen = 0; cpu_addr = '0; cpu_wdata = '0;
      ext_req = 0; ext_wen = 0; ext_addr = '0; ext_wdata = '0;
      for (int i = 0; i < (1<<ADDR_W); i++) shadow[i] = initWord(i);
      m_owner = 0; m_starve = 0; m_data = '0;
      cpu_hold = 0; ext_hold = 0; ext_gnt_seen = 0;
      @(posedge clk); #1;
      preload = 1'b0;

      $display("[TB] reset and idle");
      applyStimulus(1, 1, 0, 3, 0, 1, 0, 4, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("[TB] cpu read 0x010");
      applyStimulus(0, 1, 0, 'h10, 0, 0, 0, 0, 0);
      expectVal("t2_cpu_rvalid", cpu_rvalid, 1'b1);
      expectVal("t2_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("[TB] contention write/read 0x5");
      applyStimulus(0, 1, 1, 5, 32'h1234, 1, 0, 5, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 5, 0);
      expectVal("t3_ext_rvalid", ext_rvalid, 1'b1);
      expectVal("t3_ext_rdata", ext_rdata, 32'h1234);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("[TB] held contention for 20 cycles");
      ext_gnt_seen = 0;
      for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, 7, 0, 1, 0, 9, 0);
      expectVal("t4_ext_grants", ext_gnt_seen, GUARD ? 4 : 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("[TB] reset with ext read in flight");
      applyStimulus(0, 1, 0, 2, 0, 1, 0, 3, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 3, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      expectVal("t5_ext_rvalid", ext_rvalid, 1'b0);
      expectVal("t5_cpu_rvalid", cpu_rvalid, 1'b0);
      ext_gnt_seen = 0;
      for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 7, 0, 1, 0, 9, 0);
      expectVal("t5_starve_restart", ext_gnt_seen, GUARD ? 1 : 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("[TB] alternating reads");
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) applyStimulus(0, 1, 0, 32 + i, 0, 0, 0, 0, 0);
         else            applyStimulus(0, 0, 0, 0, 0, 1, 0, 64 + i, 0);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("[TB] random traffic");
      cr = 0; cw = 0; ca = 0; cd = 0; er = 0; ew = 0; ea = 0; ed = 0;
      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(0, 39) == 0);
         if (!cpu_hold) begin
            cr = $urandom_range(0, 99) < 60; cw = $urandom_range(0, 1);
            ca = $urandom_range(0, 15); cd = $urandom;
         end
         if (!ext_hold) begin
            er = $urandom_range(0, 99) < 50; ew = $urandom_range(0, 1);
            ea = $urandom_range(0, 15); ed = $urandom;
         end
         applyStimulus(r, cr, cw, ca, cd, er, ew, ea, ed);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
